lms_ctrl: RTL
=============

Name: lms_ctrl

Overview:
Sequencer for the LMS adaptive-filter core. After start it streams the reciprocal LUT from an external read-only memory into the LMS write-LUT port. It then issues one (u, e) sample pair every K clocks from a valid/ready sample source. It counts LMS valid_out pulses and reports done, underrun and timeout status. It replaces hand-written pacing logic in front of LMS and sits between the sample/LUT memories and LMS.

Parameters:
LUT_SIZE, 128, number of reciprocal LUT entries to load
A_IN_W, 8, LUT index width + 1 (index bus is A_IN_W-1 bits)
A_OUT_W, 13, LUT data width + 1 (data bus is A_OUT_W-1 bits)
U1_IN_W, 32, u sample width (signed)
EH_IN_W, 32, e sample width (signed)
K, 32, clocks per sample period (>= 2)
NUM_SAMPLES, 2601, samples per run
DRAIN_TIMEOUT, 4096, max clocks without valid_out while draining

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; honoured only in IDLE or DONE
abort  in  1  synchronous return to IDLE from any state
lut_rd_en  out  1  LUT memory read strobe
lut_rd_idx  out  A_IN_W-1  LUT memory read address
lut_rd_data  in  A_OUT_W-1  LUT memory data, valid 1 cycle after lut_rd_en
src_valid  in  1  sample source has a pair
src_ready  out  1  pair consumed this cycle
src_u  in  U1_IN_W  u sample
src_e  in  EH_IN_W  e sample
write_lut_in  out  1  to LMS
write_lut_idx  out  A_IN_W-1  to LMS
write_lut_data  out  A_OUT_W-1  to LMS
valid_u_in  out  1  to LMS
data_u_in  out  U1_IN_W  to LMS
valid_e_in  out  1  to LMS
data_e_in  out  EH_IN_W  to LMS
valid_out  in  1  from LMS, one per completed output vector
busy  out  1  state is not IDLE or DONE
done  out  1  held high in DONE
underrun  out  1  sticky: a sample slot found src_valid low
timeout  out  1  sticky: drain timed out
out_cnt  out  $clog2(NUM_SAMPLES+1)  valid_out pulses this run

Behaviour:
- Reset (asynchronous, reset low):
  - All outputs 0, including data buses.
  - State IDLE; all counters and sticky flags cleared.
  - Applies mid-operation as well.
- States: IDLE, LUT_LOAD, RUN, DRAIN, DONE.
- IDLE:
  - All strobes 0.
  - start -> LUT_LOAD; clears out_cnt, underrun, timeout and the sample counter.
- LUT_LOAD:
  - lut_rd_en=1 with lut_rd_idx = 0..LUT_SIZE-1, one index per cycle, starting the cycle after start.
  - Each read produces a write on the following cycle: write_lut_in=1, write_lut_idx = registered read index, write_lut_data = lut_rd_data.
  - Result is LUT_SIZE consecutive write cycles with no gaps.
  - After the last write cycle -> RUN; the period counter is cleared on entry.
- RUN:
  - Period counter runs 0..K-1 and wraps.
  - At count 0 with src_valid=1: src_ready=1 (combinational, that cycle only). src_u/src_e are registered, and valid_u_in and valid_e_in are asserted together for exactly one cycle on the next cycle.
  - data_u_in/data_e_in are 0 whenever the valids are low.
  - At count 0 with src_valid=0: the slot is skipped with no stall, underrun is set, and the sample counter does not advance.
  - src_ready is never asserted outside count 0 of RUN.
  - When the sample counter reaches NUM_SAMPLES (after the last issue cycle) -> DRAIN.
- DRAIN:
  - No further samples are issued.
  - out_cnt == NUM_SAMPLES -> DONE.
  - DRAIN_TIMEOUT consecutive clocks without valid_out -> DONE with timeout=1.
- DONE:
  - done=1, busy=0.
  - start -> LUT_LOAD (new run, status cleared on that cycle).
- out_cnt:
  - Counts valid_out in LUT_LOAD, RUN and DRAIN.
  - Saturates at NUM_SAMPLES.
  - A valid_out arriving on the cycle DRAIN is entered is counted.
  - valid_out in IDLE/DONE is ignored.
- abort:
  - Priority over start and over all transitions.
  - Next cycle: IDLE, all strobes 0.
  - Counters and flags are retained until the next start.
- start while busy is ignored.
- busy=1 in LUT_LOAD, RUN and DRAIN.

Decomposition:
- Package lms_ctrl_pkg:
  - State enum.
  - Counter width functions for sample, out_cnt and timeout.
  - Default K and NUM_SAMPLES constants, shared with the LMS top-level wiring.
- One natural sub-module, lms_ctrl_lut_loader: the LUT read/write pipeline with a done pulse.
- The top-level FSM, sample pacing and status counters stay in lms_ctrl.

Test Plan:
- Bench parameters: LUT_SIZE=4, K=4, NUM_SAMPLES=3; LMS replaced by a model.
- Start with ROM {0x11,0x22,0x33,0x44} -> write_lut_in high for exactly 4 consecutive cycles with idx 0,1,2,3 and data matching the ROM; RUN entered next.
- src_valid always 1, u={5,-6,7}, e={-1,2,-3} -> valid_u_in/valid_e_in pulses 4 clocks apart with matching data; src_ready exactly 3 pulses; DRAIN after the third.
- src_valid low at the second slot -> underrun=1; the second sample is issued 4 clocks later; still 3 samples total.
- Model returns 3 valid_out -> done=1, out_cnt=3, busy=0; a second start reruns with out_cnt reset to 0.
- Model returns only 2 valid_out, DRAIN_TIMEOUT=16 -> DONE 16 clocks after the last valid_out, timeout=1, out_cnt=2.
- Reset asserted low mid-RUN, and abort mid-LUT_LOAD -> all strobes 0 (immediately for reset, next cycle for abort), state IDLE, start ignored while busy.

Source files
------------

// File: rtl/lms_ctrl_pkg.sv
// Shared types and sizing helpers for the LMS sequencer.
// The default K and NUM_SAMPLES constants are also used by the LMS top-level wiring.
package lms_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LUT_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEFAULT_K           = 32;
    localparam int DEFAULT_NUM_SAMPLES = 2601;

    function automatic int sample_cnt_w(input int num_samples);
        return (num_samples < 1) ? 1 : $clog2(num_samples + 1);
    endfunction

    function automatic int out_cnt_w(input int num_samples);
        return (num_samples < 1) ? 1 : $clog2(num_samples + 1);
    endfunction

    // The quiet counter only needs to reach DRAIN_TIMEOUT-1 before the drain gives up.
    function automatic int timeout_cnt_w(input int drain_timeout);
        return (drain_timeout < 2) ? 1 : $clog2(drain_timeout);
    endfunction

endpackage

// File: rtl/lms_ctrl_lut_loader.sv
// Streams LUT_SIZE entries from a one-cycle-latency ROM into the LMS write-LUT port.
// A read issued in one cycle becomes a write in the next, so the writes form one gap-free burst.
module lms_ctrl_lut_loader
    import lms_ctrl_pkg::*;
#(
    parameter int LUT_SIZE = 128,
    parameter int A_IN_W   = 8,
    parameter int A_OUT_W  = 13
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               lut_rd_en,
    output logic [A_IN_W-2:0]  lut_rd_idx,
    input  logic [A_OUT_W-2:0] lut_rd_data,
    output logic               write_lut_in,
    output logic [A_IN_W-2:0]  write_lut_idx,
    output logic [A_OUT_W-2:0] write_lut_data,
    output logic               load_done
);

    localparam int IW = A_IN_W - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LUT_SIZE - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lut_rd_en     <= 1'b0;
            lut_rd_idx    <= '0;
            write_lut_in  <= 1'b0;
            write_lut_idx <= '0;
        end else if (abort) begin
            lut_rd_en     <= 1'b0;
            lut_rd_idx    <= '0;
            write_lut_in  <= 1'b0;
            write_lut_idx <= '0;
        end else begin
            write_lut_in  <= lut_rd_en;
            write_lut_idx <= lut_rd_idx;
            if (start) begin
                lut_rd_en  <= 1'b1;
                lut_rd_idx <= '0;
            end else if (lut_rd_en) begin
                if (lut_rd_idx == LAST_IDX) begin
                    lut_rd_en  <= 1'b0;
                    lut_rd_idx <= '0;
                end else begin
                    lut_rd_idx <= lut_rd_idx + 1'b1;
                end
            end
        end
    end

    // ROM data arrives exactly in the write cycle, so it is forwarded rather than registered.
    assign write_lut_data = write_lut_in ? lut_rd_data : '0;
    assign load_done      = write_lut_in && (write_lut_idx == LAST_IDX);

endmodule

// File: rtl/lms_ctrl.sv
// Top-level sequencer in front of the LMS core: LUT load, K-clock sample pacing,
// output counting and done/underrun/timeout status.
module lms_ctrl
    import lms_ctrl_pkg::*;
#(
    parameter int LUT_SIZE      = 128,
    parameter int A_IN_W        = 8,
    parameter int A_OUT_W       = 13,
    parameter int U1_IN_W       = 32,
    parameter int EH_IN_W       = 32,
    parameter int K             = DEFAULT_K,
    parameter int NUM_SAMPLES   = DEFAULT_NUM_SAMPLES,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    output logic                              lut_rd_en,
    output logic [A_IN_W-2:0]                 lut_rd_idx,
    input  logic [A_OUT_W-2:0]                lut_rd_data,
    input  logic                              src_valid,
    output logic                              src_ready,
    input  logic [U1_IN_W-1:0]                src_u,
    input  logic [EH_IN_W-1:0]                src_e,
    output logic                              write_lut_in,
    output logic [A_IN_W-2:0]                 write_lut_idx,
    output logic [A_OUT_W-2:0]                write_lut_data,
    output logic                              valid_u_in,
    output logic [U1_IN_W-1:0]                data_u_in,
    output logic                              valid_e_in,
    output logic [EH_IN_W-1:0]                data_e_in,
    input  logic                              valid_out,
    output logic                              busy,
    output logic                              done,
    output logic                              underrun,
    output logic                              timeout,
    output logic [out_cnt_w(NUM_SAMPLES)-1:0] out_cnt
);

    localparam int PW = (K < 2) ? 1 : $clog2(K);
    localparam int SW = sample_cnt_w(NUM_SAMPLES);
    localparam int OW = out_cnt_w(NUM_SAMPLES);
    localparam int TW = timeout_cnt_w(DRAIN_TIMEOUT);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(K - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(NUM_SAMPLES);
    localparam logic [OW-1:0] OUT_MAX     = OW'(NUM_SAMPLES);
    localparam logic [TW-1:0] QUIET_LAST  = TW'(DRAIN_TIMEOUT - 1);

    state_t        state, next_state;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] sample_cnt;
    logic [TW-1:0] quiet_cnt;
    logic          start_load;
    logic          load_done;
    logic          slot;
    logic          timeout_hit;

    lms_ctrl_lut_loader #(
        .LUT_SIZE (LUT_SIZE),
        .A_IN_W   (A_IN_W),
        .A_OUT_W  (A_OUT_W)
    ) u_loader (
        .clock          (clock),
        .reset          (reset),
        .start          (start_load),
        .abort          (abort),
        .lut_rd_en      (lut_rd_en),
        .lut_rd_idx     (lut_rd_idx),
        .lut_rd_data    (lut_rd_data),
        .write_lut_in   (write_lut_in),
        .write_lut_idx  (write_lut_idx),
        .write_lut_data (write_lut_data),
        .load_done      (load_done)
    );

    assign start_load  = (state == ST_IDLE || state == ST_DONE) && start && !abort;
    assign slot        = (state == ST_RUN) && (period_cnt == '0);
    assign src_ready   = slot && src_valid && !abort;
    assign busy        = (state == ST_LUT_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign timeout_hit = (state == ST_DRAIN) && !abort && (out_cnt != OUT_MAX)
                         && !valid_out && (quiet_cnt == QUIET_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) next_state = ST_LUT_LOAD;
                ST_LUT_LOAD:      if (load_done) next_state = ST_RUN;
                ST_RUN:           if (sample_cnt == SAMPLE_LAST) next_state = ST_DRAIN;
                ST_DRAIN:         if (out_cnt == OUT_MAX || timeout_hit) next_state = ST_DONE;
                default:          next_state = ST_IDLE;
            endcase
        end
    end

    // Status survives abort and is only cleared by the next accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            sample_cnt <= '0;
            quiet_cnt  <= '0;
            out_cnt    <= '0;
            underrun   <= 1'b0;
            timeout    <= 1'b0;
        end else if (start_load) begin
            period_cnt <= '0;
            sample_cnt <= '0;
            quiet_cnt  <= '0;
            out_cnt    <= '0;
            underrun   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (state == ST_RUN && !abort) begin
                period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
            end else begin
                period_cnt <= '0;
            end
            if (src_ready) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (slot && !src_valid && !abort) begin
                underrun <= 1'b1;
            end
            if (busy && valid_out && out_cnt != OUT_MAX) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (state == ST_DRAIN && !valid_out) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end else begin
                quiet_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_u_in <= 1'b0;
            valid_e_in <= 1'b0;
            data_u_in  <= '0;
            data_e_in  <= '0;
        end else if (src_ready) begin
            valid_u_in <= 1'b1;
            valid_e_in <= 1'b1;
            data_u_in  <= src_u;
            data_e_in  <= src_e;
        end else begin
            valid_u_in <= 1'b0;
            valid_e_in <= 1'b0;
            data_u_in  <= '0;
            data_e_in  <= '0;
        end
    end

endmodule
